// File: rtl/seq_csa_sub.sv
// Multi-cycle carry-select subtractor (a - b), one SLICE-bit slice per cycle, LSB first.
// Define SEQ_CSA_SUB_OVF_EN to build the signed-overflow flag; otherwise o_ovf is tied low.

module seq_csa_sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] nb,
    input  logic         cin,
    output logic [W:0]   sum
);
    assign sum = {1'b0, a} + {1'b0, nb} + {{W{1'b0}}, cin};
endmodule

module seq_csa_sub #(
    parameter int WIDTH = 37,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_ovf
);
    localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
    localparam int REM    = WIDTH - SLICE * (NSLICE - 1);
    localparam int PW     = NSLICE * SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  nb_r;
    logic              carry;
    logic [CW-1:0]     cnt;

    // Operands zero-padded to whole slices so the last slice needs no special muxing.
    logic [NSLICE-1:0][SLICE-1:0] a_arr;
    logic [NSLICE-1:0][SLICE-1:0] nb_arr;
    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  nb_sl;
    logic [SLICE:0]    sum0;
    logic [SLICE:0]    sum1;
    logic [SLICE:0]    sum_sel;
    logic              last;
    logic              cout;

    assign a_arr  = PW'(a_r);
    assign nb_arr = PW'(nb_r);
    assign a_sl   = a_arr[cnt];
    assign nb_sl  = nb_arr[cnt];

    seq_csa_sub_slice #(.W(SLICE)) u_add0 (.a(a_sl), .nb(nb_sl), .cin(1'b0), .sum(sum0));
    seq_csa_sub_slice #(.W(SLICE)) u_add1 (.a(a_sl), .nb(nb_sl), .cin(1'b1), .sum(sum1));

    assign sum_sel = carry ? sum1 : sum0;
    assign last    = (cnt == LAST);
    // Padding bits are zero, so the true carry of a short last slice lands at bit REM.
    assign cout    = last ? sum_sel[REM] : sum_sel[SLICE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_diff   <= '0;
            o_borrow <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_r      <= '0;
            nb_r     <= '0;
`ifdef SEQ_CSA_SUB_OVF_EN
            o_ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        a_r      <= i_a;
                        nb_r     <= ~i_b;
                        carry    <= 1'b1;
                        cnt      <= '0;
                        o_diff   <= '0;
                        o_borrow <= 1'b0;
                        o_ready  <= 1'b0;
                        state    <= RUN;
`ifdef SEQ_CSA_SUB_OVF_EN
                        o_ovf    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (cnt == CW'(i / SLICE))
                            o_diff[i] <= sum_sel[i % SLICE];
                    end
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        o_borrow <= ~cout;
                        o_valid  <= 1'b1;
                        state    <= DONE;
`ifdef SEQ_CSA_SUB_OVF_EN
                        // Signs of a and b differ exactly when a and ~b share a sign.
                        o_ovf    <= (a_r[WIDTH-1] == nb_r[WIDTH-1]) &&
                                    (sum_sel[REM-1] != a_r[WIDTH-1]);
`endif
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SEQ_CSA_SUB_OVF_EN
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_csa_sub.sv
// Directed-vector bench for seq_csa_sub at default parameters (37-bit, 4-bit slices).
module tb_seq_csa_sub;
    localparam int W = 37;
`ifdef SEQ_CSA_SUB_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_diff;
    logic         o_borrow;
    logic         o_ovf;

    int checks = 0;
    int errors = 0;

    seq_csa_sub dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_diff(o_diff), .o_borrow(o_borrow), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one request, scramble the input bus, wait for o_valid and check the result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input logic exp_bw, input logic exp_ov);
        int n;
        chk({tag, "_rdy"}, 64'(o_ready), 64'd1);
        i_a = a; i_b = b; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_a = 37'h0A_5A5A_5A5A; i_b = 37'h15_A5A5_A5A5;
        n = 0;
        while (!o_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd10);
        chk({tag, "_diff"}, 64'(o_diff), 64'(exp_d));
        chk({tag, "_bw"}, 64'(o_borrow), 64'(exp_bw));
        chk({tag, "_ovf"}, 64'(o_ovf), 64'(exp_ov));
    endtask

    task automatic consume(input string tag);
        i_ready = 1'b1;
        tick();
        chk({tag, "_vld0"}, 64'(o_valid), 64'd0);
        chk({tag, "_rdy1"}, 64'(o_ready), 64'd1);
        i_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdy", 64'(o_ready), 64'd1);
        chk("rst_vld", 64'(o_valid), 64'd0);
        chk("rst_diff", 64'(o_diff), 64'd0);
        chk("rst_bw", 64'(o_borrow), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);

        run_op("basic", 37'd5, 37'd3, 37'd2, 1'b0, 1'b0);
        consume("basic");

        run_op("under", 37'd0, 37'd1, 37'h1F_FFFF_FFFF, 1'b1, 1'b0);
        consume("under");

        run_op("equal", 37'h15_5555_5555, 37'h15_5555_5555, 37'd0, 1'b0, 1'b0);
        consume("equal");

        // Borrow ripples across every slice; most-negative minus positive overflows.
        run_op("chain", 37'h10_0000_0000, 37'h0F_FFFF_FFFF, 37'd1, 1'b0, OVF);
        consume("chain");

        run_op("bp", 37'h1F_FFFF_FFFF, 37'd1, 37'h1F_FFFF_FFFE, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            i_valid = k[0];
            i_a = 37'd77; i_b = 37'd11;
            tick();
            chk("bp_vld", 64'(o_valid), 64'd1);
            chk("bp_diff", 64'(o_diff), 64'h1F_FFFF_FFFE);
            chk("bp_rdy", 64'(o_ready), 64'd0);
        end
        i_valid = 1'b0;
        consume("bp");
        tick();
        chk("bp_no_new", 64'(o_valid), 64'd0);

        // Abort mid-operation, then make sure the unit recovers cleanly.
        i_a = 37'd100; i_b = 37'd1; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; i_ready = 1'b1; i_valid = 1'b1;
        tick();
        rst = 1'b0; i_ready = 1'b0; i_valid = 1'b0;
        chk("abort_vld", 64'(o_valid), 64'd0);
        chk("abort_rdy", 64'(o_ready), 64'd1);
        chk("abort_diff", 64'(o_diff), 64'd0);
        run_op("after", 37'd9, 37'd4, 37'd5, 1'b0, 1'b0);
        consume("after");

        run_op("ovf", 37'h10_0000_0000, 37'd1, 37'h0F_FFFF_FFFF, 1'b0, OVF);
        consume("ovf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
